// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order, the active-low hex glyph
// table and the nibble encoder used by the scan driver.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // Segment bit positions inside a seg_t (active-low on the pins)
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Glyphs 0..F, bit0 = a .. bit6 = g, 0 = segment lit
  localparam seg_t SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg_t seg7_encode(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Refresh prescaler: free-running 0..REFRESH_CYCLES-1 counter whose terminal
// count is presented as a one-cycle step pulse.
module seg7_prescaler #(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic clk,
  input  logic srst,
  output logic step
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    step    = (count_q == TERMINAL);
    count_d = step ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver: loads land in a pending buffer and are
// promoted to the displayed shadow only on the frame wrap, so frames never tear.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_CYCLES = 100000,
  parameter int BLANK_LZ       = 1
) (
  input  logic                  Clk_signal,
  input  logic                  Reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  enable,
  output logic [6:0]            hex_reg,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   anodes,
  output logic                  frame_tick
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic step;
  logic wrap;

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [4*N_DIGITS-1:0] shad_val_q, shad_val_d;
  logic [N_DIGITS-1:0]   shad_dp_q, shad_dp_d;

  logic [N_DIGITS-1:0]   anodes_q, anodes_d;
  seg_t                  hex_q, hex_d;
  logic                  dp_q, dp_d;
  logic                  frame_tick_q, frame_tick_d;

  logic [N_DIGITS-1:0]   digit_sel;
  logic [N_DIGITS-1:0]   lz_zero;
  logic [3:0]            nib [N_DIGITS];
  logic [3:0]            cur_nib;
  logic                  cur_lz;
  logic                  cur_dp;
  logic                  blank;

  seg7_prescaler #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_prescaler (
    .clk (Clk_signal),
    .srst(Reset),
    .step(step)
  );

  // lz_zero[i]: every shadow digit from the top down to i is zero
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign digit_sel[gi] = (idx_q == IDX_W'(gi));
    assign nib[gi]       = shad_val_q[4*gi +: 4];
    assign lz_zero[gi]   = ~|shad_val_q[4*N_DIGITS-1:4*gi];
  end

  always_comb begin
    wrap  = step && (idx_q == LAST_IDX);
    idx_d = idx_q;
    if (step) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    shad_val_d   = shad_val_q;
    shad_dp_d    = shad_dp_q;

    // A load on the wrap itself bypasses pending and wins over older data
    if (wrap) begin
      if (load) begin
        shad_val_d = value;
        shad_dp_d  = dp_in;
      end else if (pend_valid_q) begin
        shad_val_d = pend_val_q;
        shad_dp_d  = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_lz  = 1'b0;
    cur_dp  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digit_sel[i]) begin
        cur_nib = nib[i];
        cur_lz  = (i != 0) && lz_zero[i];
        cur_dp  = shad_dp_q[i];
      end
    end
    blank = (BLANK_LZ != 0) && cur_lz;

    // A blanked digit keeps its anode and decimal point; only glyph goes dark
    anodes_d     = enable ? ~digit_sel : '1;
    hex_d        = (enable && !blank) ? seg7_encode(cur_nib) : SEG_BLANK;
    dp_d         = !(enable && cur_dp);
    frame_tick_d = wrap;
  end

  always_ff @(posedge Clk_signal) begin
    if (Reset) begin
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      shad_val_q   <= '0;
      shad_dp_q    <= '0;
      anodes_q     <= '1;
      hex_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      shad_val_q   <= shad_val_d;
      shad_dp_q    <= shad_dp_d;
      anodes_q     <= anodes_d;
      hex_q        <= hex_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign anodes     = anodes_q;
  assign hex_reg    = hex_q;
  assign dp_out     = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4-cycle refresh): each
// displayed digit is one transaction, popped whenever the outputs change.
module tb_seg7_scan_driver;

  logic        Clk_signal = 1'b0;
  logic        Reset      = 1'b1;
  logic        load       = 1'b0;
  logic [15:0] value      = '0;
  logic [3:0]  dp_in      = '0;
  logic        enable     = 1'b0;
  logic [6:0]  hex_reg;
  logic        dp_out;
  logic [3:0]  anodes;
  logic        frame_tick;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [11:0] exp_q [$];
  bit          mon_en = 1'b0;
  logic [11:0] prev   = '0;
  int          tick_cnt = 0;

  always #5 Clk_signal = ~Clk_signal;

  seg7_scan_driver #(
    .N_DIGITS      (4),
    .REFRESH_CYCLES(4),
    .BLANK_LZ      (1)
  ) dut (
    .Clk_signal(Clk_signal),
    .Reset     (Reset),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .enable    (enable),
    .hex_reg   (hex_reg),
    .dp_out    (dp_out),
    .anodes    (anodes),
    .frame_tick(frame_tick)
  );

  function automatic logic [11:0] ent(input logic [3:0] an, input logic [6:0] hx, input logic dp);
    return {an, hx, dp};
  endfunction

  // Monitor: a change on {anodes,hex_reg,dp_out} is one displayed transaction
  always @(posedge Clk_signal) begin
    logic [11:0] cur;
    logic [11:0] e;
    #1;
    cur = {anodes, hex_reg, dp_out};
    if (mon_en && cur !== prev) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: got an=%b hex=%b dp=%b, required no change", cur[11:8], cur[7:1], cur[0]);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          n_fail++;
          $display("FAIL digit_seq: got an=%b hex=%b dp=%b, required an=%b hex=%b dp=%b",
                   cur[11:8], cur[7:1], cur[0], e[11:8], e[7:1], e[0]);
        end else begin
          $display("digit an=%b hex=%b dp=%b ok", cur[11:8], cur[7:1], cur[0]);
        end
      end
    end
    prev = cur;
    if (Reset) begin
      tick_cnt = 0;
    end else begin
      tick_cnt++;
      if (frame_tick) begin
        n_cmp++;
        if (tick_cnt != 16) begin
          n_fail++;
          $display("FAIL tick_period: got %0d cycles, required 16", tick_cnt);
        end
        tick_cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end else begin
      $display("check %s = %0h ok", name, got);
    end
  endtask

  task automatic push4(input logic [11:0] e0, input logic [11:0] e1,
                       input logic [11:0] e2, input logic [11:0] e3);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    exp_q.push_back(e3);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk_signal);
      n++;
      if (frame_tick) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL tick_timeout: got no frame_tick in %0d cycles, required one", n);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    load  = 1'b1;
    value = v;
    dp_in = d;
    @(negedge Clk_signal);
    load  = 1'b0;
  endtask

  // Hand-computed frames (digit 0 first)
  logic [11:0] z0, z1, z2, z3;   // shadow 0000, dp none
  logic [11:0] c0, c1, c2, c3;   // shadow E3D6, dp 0001
  logic [11:0] dark;

  initial begin
    int n;
    z0 = ent(4'b1110, 7'h40, 1'b1); z1 = ent(4'b1101, 7'h7F, 1'b1);
    z2 = ent(4'b1011, 7'h7F, 1'b1); z3 = ent(4'b0111, 7'h7F, 1'b1);
    c0 = ent(4'b1110, 7'h02, 1'b0); c1 = ent(4'b1101, 7'h21, 1'b1);
    c2 = ent(4'b1011, 7'h30, 1'b1); c3 = ent(4'b0111, 7'h06, 1'b1);
    dark = ent(4'b1111, 7'h7F, 1'b1);

    repeat (3) @(negedge Clk_signal);
    chk("reset_anodes", anodes, 4'hF);
    chk("reset_hex", hex_reg, 7'h7F);
    chk("reset_dp", dp_out, 1);
    chk("reset_tick", frame_tick, 0);
    mon_en = 1'b1;
    Reset  = 1'b0;

    wait_tick(n);
    chk("first_tick_latency", n, 16);
    wait_tick(n);                                  // disabled frame stays dark

    enable = 1'b1;
    push4(z0, z1, z2, z3);
    pulse_load(16'h1F08, 4'b0000);
    wait_tick(n);

    push4(ent(4'b1110, 7'h00, 1'b1), ent(4'b1101, 7'h40, 1'b1),
          ent(4'b1011, 7'h0E, 1'b1), ent(4'b0111, 7'h79, 1'b1));
    pulse_load(16'h0005, 4'b0000);
    wait_tick(n);

    push4(ent(4'b1110, 7'h12, 1'b1), z1, z2, z3);
    pulse_load(16'h0000, 4'b0100);
    wait_tick(n);

    // Two loads while digit 1 is lit: old value holds, last load wins
    push4(z0, z1, ent(4'b1011, 7'h7F, 1'b0), z3);
    repeat (6) @(negedge Clk_signal);
    pulse_load(16'h7777, 4'b1111);
    pulse_load(16'h8421, 4'b0100);
    wait_tick(n);

    push4(ent(4'b1110, 7'h79, 1'b1), ent(4'b1101, 7'h24, 1'b1),
          ent(4'b1011, 7'h19, 1'b0), ent(4'b0111, 7'h00, 1'b1));
    repeat (15) @(negedge Clk_signal);
    load  = 1'b1;                                  // coincides with wrapping step
    value = 16'hE3D6;
    dp_in = 4'b0001;
    wait_tick(n);
    load  = 1'b0;
    chk("load_on_wrap_tick", n, 1);

    push4(c0, c1, c2, c3);
    wait_tick(n);
    push4(c0, c1, c2, c3);
    wait_tick(n);

    enable = 1'b0;
    exp_q.push_back(dark);
    wait_tick(n);
    enable = 1'b1;
    push4(c0, c1, c2, c3);
    wait_tick(n);

    // Reset while digit 1 is lit discards the pending 9999
    exp_q.push_back(c0);
    exp_q.push_back(c1);
    exp_q.push_back(dark);
    pulse_load(16'h9999, 4'b1111);
    repeat (5) @(negedge Clk_signal);
    Reset = 1'b1;
    @(negedge Clk_signal);
    Reset = 1'b0;
    push4(z0, z1, z2, z3);
    wait_tick(n);
    chk("post_reset_tick_latency", n, 16);
    push4(z0, z1, z2, z3);
    wait_tick(n);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
